ysyx_25040111_icache_sa: RTL and testbench

Parametrised set-associative instruction cache between IFU and the memory bridge. It succeeds the direct-mapped I-cache with configurable ways, sets and line size, per-set round-robin replacement, fence.i flush, error propagation and hit/miss counters. Misses refill a whole line, as one burst or as sequential single-beat reads.

---
 rtl/ysyx_25040111_cache_pkg.sv | 36 +++
 rtl/ysyx_25040111_cache_way.sv | 46 ++++
 rtl/ysyx_25040111_icache_sa.sv | 159 +++++++++++++++
 tb/tb_ysyx_25040111_icache_sa.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040111_cache_pkg.sv
// Shared cache definitions: controller states and address-split helpers,
// common to the I-cache and the future D-cache.
package ysyx_25040111_cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_RESP   = 2'd2
  } cache_state_e;

  function automatic int cache_words(input int line_ls);
    return 1 << (line_ls - 2);
  endfunction

  // Word-index width; a one-word line still gets a 1-bit index to avoid zero-width vectors
  function automatic int cache_wb(input int line_ls);
    return (line_ls > 2) ? line_ls - 2 : 1;
  endfunction

  function automatic int cache_tag_w(input int sets_ls, input int line_ls);
    return 32 - sets_ls - line_ls;
  endfunction

  function automatic logic [31:0] cache_tag(input logic [31:0] a, input int sets_ls, input int line_ls);
    return a >> (sets_ls + line_ls);
  endfunction

  function automatic logic [31:0] cache_set(input logic [31:0] a, input int sets_ls, input int line_ls);
    return (a >> line_ls) & ((32'd1 << sets_ls) - 32'd1);
  endfunction

  function automatic logic [31:0] cache_word(input logic [31:0] a, input int line_ls);
    return (a >> 2) & ((32'd1 << (line_ls - 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/ysyx_25040111_cache_way.sv
// One cache way: per-set valid bit and tag, line data, and a combinational
// hit compare for the currently addressed set.
module ysyx_25040111_cache_way
  import ysyx_25040111_cache_pkg::*;
#(
  parameter int SETS_Ls = 4,
  parameter int LINE_Ls = 4
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     flush,
  input  logic [SETS_Ls-1:0]                       set,
  input  logic [cache_wb(LINE_Ls)-1:0]             rd_word,
  input  logic [cache_tag_w(SETS_Ls, LINE_Ls)-1:0] tag,
  output logic                                     hit,
  output logic                                     valid,
  output logic [31:0]                              rdata,
  input  logic                                     wr_en,
  input  logic [cache_wb(LINE_Ls)-1:0]             wr_word,
  input  logic [31:0]                              wr_data,
  input  logic                                     inst_en
);
  localparam int SETS  = 1 << SETS_Ls;
  localparam int WB    = cache_wb(LINE_Ls);
  localparam int TAG_W = cache_tag_w(SETS_Ls, LINE_Ls);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS << WB];

  always_ff @(posedge clock) begin
    if (reset || flush) valid_q <= '0;
    else if (inst_en)   valid_q[set] <= 1'b1;
  end

  // Tag and data storage carry no reset; valid alone qualifies them
  always_ff @(posedge clock) begin
    if (inst_en) tag_q[set] <= tag;
    if (wr_en)   data_q[{set, wr_word}] <= wr_data;
  end

  assign valid = valid_q[set];
  assign hit   = valid_q[set] && (tag_q[set] == tag);
  assign rdata = data_q[{set, rd_word}];

endmodule

// File: rtl/ysyx_25040111_icache_sa.sv
// Set-associative instruction cache with round-robin replacement, fence.i
// flush, bus-error propagation and saturating hit/miss counters.
module ysyx_25040111_icache_sa
  import ysyx_25040111_cache_pkg::*;
#(
  parameter int WAYS_Ls = 1,
  parameter int SETS_Ls = 4,
  parameter int LINE_Ls = 4,
  parameter bit BURST   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        ifu_valid,
  output logic        ifu_ready,
  output logic [31:0] data,
  output logic        ifu_err,
  input  logic        flush,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_len,
  output logic        mem_burst,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  input  logic        mem_err,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int WAYS  = 1 << WAYS_Ls;
  localparam int SETS  = 1 << SETS_Ls;
  localparam int WORDS = cache_words(LINE_Ls);
  localparam int WB    = cache_wb(LINE_Ls);
  localparam int TAG_W = cache_tag_w(SETS_Ls, LINE_Ls);

  cache_state_e       state_q, state_d;
  logic [TAG_W-1:0]   tag_idx;
  logic [SETS_Ls-1:0] set_idx;
  logic [WB-1:0]      word_idx, beat_q;
  logic [WAYS_Ls-1:0] victim_q, first_inv;
  logic [WAYS_Ls-1:0] victim_ptr_q [SETS];
  logic [WAYS-1:0]    way_hit, way_valid;
  logic [31:0]        way_rdata [WAYS];
  logic [31:0]        hit_data;
  logic               any_inv, all_valid_q, flush_pend_q, flush_now, lookup;
  logic               beat_ok, last_beat, install;

  assign tag_idx   = TAG_W'(cache_tag(addr, SETS_Ls, LINE_Ls));
  assign set_idx   = SETS_Ls'(cache_set(addr, SETS_Ls, LINE_Ls));
  assign word_idx  = WB'(cache_word(addr, LINE_Ls));
  assign beat_ok   = (state_q == S_REFILL) && mem_ready && !mem_err;
  assign last_beat = (beat_q == WB'(WORDS - 1));
  assign install   = beat_ok && last_beat;
  assign mem_len   = BURST ? 8'(WORDS - 1) : 8'd0;
  assign mem_burst = BURST;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    ysyx_25040111_cache_way #(.SETS_Ls(SETS_Ls), .LINE_Ls(LINE_Ls)) u_way (
      .clock   (clock),
      .reset   (reset),
      .flush   (flush_now),
      .set     (set_idx),
      .rd_word (word_idx),
      .tag     (tag_idx),
      .hit     (way_hit[g]),
      .valid   (way_valid[g]),
      .rdata   (way_rdata[g]),
      .wr_en   (beat_ok && (victim_q == WAYS_Ls'(g))),
      .wr_word (beat_q),
      .wr_data (mem_data),
      .inst_en (install && (victim_q == WAYS_Ls'(g)))
    );
  end

  // Lowest-index invalid way wins; hit data is an OR over one-hot hits
  always_comb begin
    hit_data  = '0;
    first_inv = '0;
    any_inv   = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) hit_data = hit_data | way_rdata[w];
      if (!way_valid[w]) begin
        first_inv = WAYS_Ls'(w);
        any_inv   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    flush_now = 1'b0;
    lookup    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush || flush_pend_q) flush_now = 1'b1;
        else if (ifu_valid && !ifu_ready) begin
          lookup = 1'b1;
          if (way_hit == '0) state_d = S_REFILL;
        end
      end
      S_REFILL: if (mem_ready && (mem_err || last_beat)) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ifu_ready    <= 1'b0;
      ifu_err      <= 1'b0;
      data         <= '0;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      flush_pend_q <= 1'b0;
      beat_q       <= '0;
      victim_q     <= '0;
      all_valid_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) victim_ptr_q[s] <= '0;
    end else begin
      state_q   <= state_d;
      ifu_ready <= 1'b0;
      if (state_q != S_IDLE && flush) flush_pend_q <= 1'b1;
      else if (flush_now)             flush_pend_q <= 1'b0;
      if (lookup && way_hit != '0) begin
        data      <= hit_data;
        ifu_ready <= 1'b1;
        hit_cnt   <= hit_cnt + {31'd0, hit_cnt != '1};
      end
      if (lookup && way_hit == '0) begin
        miss_cnt    <= miss_cnt + {31'd0, miss_cnt != '1};
        victim_q    <= any_inv ? first_inv : victim_ptr_q[set_idx];
        all_valid_q <= !any_inv;
        mem_addr    <= {addr[31:LINE_Ls], {LINE_Ls{1'b0}}};
        mem_valid   <= 1'b1;
        beat_q      <= '0;
      end
      if (state_q == S_REFILL && mem_ready) begin
        if (mem_err) begin
          mem_valid <= 1'b0;
          ifu_err   <= 1'b1;
          ifu_ready <= 1'b1;
        end else begin
          beat_q <= beat_q + 1'b1;
          if (!BURST) mem_addr <= mem_addr + 32'd4;
          if (beat_q == word_idx) data <= mem_data;
          if (last_beat) begin
            mem_valid <= 1'b0;
            ifu_ready <= 1'b1;
            if (all_valid_q) victim_ptr_q[set_idx] <= victim_q + 1'b1;
          end
        end
      end
      if (state_q == S_RESP) ifu_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_icache_sa.sv
// Directed bench for the set-associative I-cache: burst and single-beat
// refills, way conflicts, bus errors, flush and reset during refill.
module tb_ysyx_25040111_icache_sa;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic        ifu_valid = 1'b0;
  logic        flush = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_err = 1'b0;
  logic        sel = 1'b0;

  logic        ifu_ready0, ifu_err0, mem_valid0, mem_burst0;
  logic        ifu_ready1, ifu_err1, mem_valid1, mem_burst1;
  logic [31:0] data0, mem_addr0, hit_cnt0, miss_cnt0;
  logic [31:0] data1, mem_addr1, hit_cnt1, miss_cnt1;
  logic [7:0]  mem_len0, mem_len1;

  logic        r_ready, r_err, r_mvalid;
  logic [31:0] r_data, r_maddr;

  int checks = 0;
  int errors = 0;
  logic [31:0] beat_data [4];
  logic [31:0] seen_addr [4];

  always #5 clock = ~clock;

  ysyx_25040111_icache_sa #(.WAYS_Ls(1), .SETS_Ls(4), .LINE_Ls(4), .BURST(1'b1)) dut (
    .clock(clock), .reset(reset), .addr(addr), .ifu_valid(ifu_valid && !sel),
    .ifu_ready(ifu_ready0), .data(data0), .ifu_err(ifu_err0), .flush(flush),
    .mem_valid(mem_valid0), .mem_addr(mem_addr0), .mem_len(mem_len0), .mem_burst(mem_burst0),
    .mem_ready(mem_ready && !sel), .mem_data(mem_data), .mem_err(mem_err),
    .hit_cnt(hit_cnt0), .miss_cnt(miss_cnt0));

  ysyx_25040111_icache_sa #(.WAYS_Ls(1), .SETS_Ls(4), .LINE_Ls(4), .BURST(1'b0)) dut_sb (
    .clock(clock), .reset(reset), .addr(addr), .ifu_valid(ifu_valid && sel),
    .ifu_ready(ifu_ready1), .data(data1), .ifu_err(ifu_err1), .flush(flush),
    .mem_valid(mem_valid1), .mem_addr(mem_addr1), .mem_len(mem_len1), .mem_burst(mem_burst1),
    .mem_ready(mem_ready && sel), .mem_data(mem_data), .mem_err(mem_err),
    .hit_cnt(hit_cnt1), .miss_cnt(miss_cnt1));

  assign r_ready  = sel ? ifu_ready1 : ifu_ready0;
  assign r_err    = sel ? ifu_err1   : ifu_err0;
  assign r_mvalid = sel ? mem_valid1 : mem_valid0;
  assign r_data   = sel ? data1      : data0;
  assign r_maddr  = sel ? mem_addr1  : mem_addr0;

  // One fetch with an inline memory responder; ends one idle cycle after ifu_ready.
  task automatic fetch(input logic [31:0] a, input int err_beat, input int flush_beat,
                       input bit flush_start, output logic [31:0] d, output logic e, output int cyc);
    int  beat = 0;
    bit  got = 0;
    cyc = 0; d = '0; e = 1'b0;
    addr = a; ifu_valid = 1'b1; flush = flush_start;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clock); #1;
      cyc++;
      flush = 1'b0;
      if (r_ready) begin
        got = 1; d = r_data; e = r_err;
        mem_ready = 1'b0; mem_err = 1'b0;
      end else if (r_mvalid && beat < 4) begin
        mem_ready = 1'b1; mem_data = beat_data[beat]; mem_err = (beat == err_beat);
        seen_addr[beat] = r_maddr;
        flush = (beat == flush_beat);
        beat++;
      end else begin
        mem_ready = 1'b0; mem_err = 1'b0;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fetch_timeout addr=%h: got no ifu_ready within 40 cycles, expected one", a);
    end
    ifu_valid = 1'b0; mem_ready = 1'b0; mem_err = 1'b0; flush = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic set_beats(input logic [31:0] b0, b1, b2, b3);
    beat_data[0] = b0; beat_data[1] = b1; beat_data[2] = b2; beat_data[3] = b3;
  endtask

  task automatic test_reset();
    checks++;
    if (ifu_ready0 !== 1'b0 || mem_valid0 !== 1'b0 || ifu_err0 !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: ready=%b mem_valid=%b err=%b, expected 0 0 0", ifu_ready0, mem_valid0, ifu_err0);
    end
    checks++;
    if (data0 !== 32'h0 || mem_addr0 !== 32'h0 || hit_cnt0 !== 32'h0 || miss_cnt0 !== 32'h0) begin
      errors++; $display("FAIL reset_regs: data=%h mem_addr=%h hit=%0d miss=%0d, expected all 0", data0, mem_addr0, hit_cnt0, miss_cnt0);
    end
    checks++;
    if (mem_len0 !== 8'd3 || mem_burst0 !== 1'b1) begin
      errors++; $display("FAIL reset_len: mem_len=%0d burst=%b, expected 3 1", mem_len0, mem_burst0);
    end
  endtask

  task automatic test_cold_miss();
    logic [31:0] d; logic e; int cyc;
    set_beats(32'h11, 32'h22, 32'h33, 32'h44);
    fetch(32'h8000_0000, -1, -1, 0, d, e, cyc);
    checks++;
    if (d !== 32'h11 || e !== 1'b0 || cyc != 5) begin
      errors++; $display("FAIL cold_miss: data=%h err=%b lat=%0d, expected 11 0 5", d, e, cyc);
    end
    checks++;
    if (seen_addr[0] !== 32'h8000_0000 || seen_addr[3] !== 32'h8000_0000 || miss_cnt0 !== 32'd1) begin
      errors++; $display("FAIL cold_miss_bus: addr0=%h addr3=%h miss=%0d, expected 80000000 80000000 1", seen_addr[0], seen_addr[3], miss_cnt0);
    end
    fetch(32'h8000_0008, -1, -1, 0, d, e, cyc);
    checks++;
    if (d !== 32'h33 || cyc != 1 || hit_cnt0 !== 32'd1) begin
      errors++; $display("FAIL refetch_hit: data=%h lat=%0d hit=%0d, expected 33 1 1", d, cyc, hit_cnt0);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d; logic e; int cyc;
    set_beats(32'hA1, 32'hA2, 32'hA3, 32'hA4);
    fetch(32'h8000_0100, -1, -1, 0, d, e, cyc);
    set_beats(32'hB1, 32'hB2, 32'hB3, 32'hB4);
    fetch(32'h8000_0200, -1, -1, 0, d, e, cyc);
    checks++;
    if (d !== 32'hB1 || cyc != 5 || miss_cnt0 !== 32'd3) begin
      errors++; $display("FAIL third_fill: data=%h lat=%0d miss=%0d, expected B1 5 3", d, cyc, miss_cnt0);
    end
    fetch(32'h8000_0104, -1, -1, 0, d, e, cyc);
    checks++;
    if (d !== 32'hA2 || cyc != 1) begin
      errors++; $display("FAIL survivor_hit: data=%h lat=%0d, expected A2 1", d, cyc);
    end
    fetch(32'h8000_0204, -1, -1, 0, d, e, cyc);
    checks++;
    if (d !== 32'hB2 || cyc != 1) begin
      errors++; $display("FAIL newest_hit: data=%h lat=%0d, expected B2 1", d, cyc);
    end
    set_beats(32'hC1, 32'hC2, 32'hC3, 32'hC4);
    fetch(32'h8000_000C, -1, -1, 0, d, e, cyc);
    checks++;
    if (d !== 32'hC4 || cyc != 5 || miss_cnt0 !== 32'd4 || hit_cnt0 !== 32'd3) begin
      errors++; $display("FAIL evicted_miss: data=%h lat=%0d miss=%0d hit=%0d, expected C4 5 4 3", d, cyc, miss_cnt0, hit_cnt0);
    end
  endtask

  task automatic test_mem_err();
    logic [31:0] d; logic e; int cyc;
    set_beats(32'hE1, 32'hE2, 32'hE3, 32'hE4);
    fetch(32'h8000_0040, 2, -1, 0, d, e, cyc);
    checks++;
    if (e !== 1'b1 || cyc != 4) begin
      errors++; $display("FAIL err_resp: err=%b lat=%0d, expected 1 4", e, cyc);
    end
    checks++;
    if (ifu_err0 !== 1'b0 || ifu_ready0 !== 1'b0 || mem_valid0 !== 1'b0) begin
      errors++; $display("FAIL err_clear: err=%b ready=%b mem_valid=%b, expected 0 0 0", ifu_err0, ifu_ready0, mem_valid0);
    end
    fetch(32'h8000_0040, -1, -1, 0, d, e, cyc);
    checks++;
    if (d !== 32'hE1 || e !== 1'b0 || cyc != 5) begin
      errors++; $display("FAIL err_refetch: data=%h err=%b lat=%0d, expected E1 0 5", d, e, cyc);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d; logic e; int cyc; logic [31:0] m;
    set_beats(32'hF1, 32'hF2, 32'hF3, 32'hF4);
    fetch(32'h8000_0088, -1, 1, 0, d, e, cyc);
    checks++;
    if (d !== 32'hF3 || e !== 1'b0 || cyc != 5) begin
      errors++; $display("FAIL flush_refill: data=%h err=%b lat=%0d, expected F3 0 5", d, e, cyc);
    end
    m = miss_cnt0;
    fetch(32'h8000_0084, -1, -1, 0, d, e, cyc);
    checks++;
    if (d !== 32'hF2 || cyc != 6 || miss_cnt0 !== m + 32'd1) begin
      errors++; $display("FAIL flush_pend_miss: data=%h lat=%0d miss=%0d, expected F2 6 %0d", d, cyc, miss_cnt0, m + 32'd1);
    end
    // Line at 0x80000084 is valid now; flush with the request must still force a miss
    set_beats(32'h61, 32'h62, 32'h63, 32'h64);
    fetch(32'h8000_0084, -1, -1, 1, d, e, cyc);
    checks++;
    if (d !== 32'h62 || cyc != 6 || miss_cnt0 !== m + 32'd2) begin
      errors++; $display("FAIL idle_flush: data=%h lat=%0d miss=%0d, expected 62 6 %0d", d, cyc, miss_cnt0, m + 32'd2);
    end
  endtask

  task automatic test_single_beat();
    logic [31:0] d; logic e; int cyc;
    sel = 1'b1;
    set_beats(32'hD1, 32'hD2, 32'hD3, 32'hD4);
    checks++;
    if (mem_len1 !== 8'd0 || mem_burst1 !== 1'b0) begin
      errors++; $display("FAIL sb_len: mem_len=%0d burst=%b, expected 0 0", mem_len1, mem_burst1);
    end
    fetch(32'h3000_000C, -1, -1, 0, d, e, cyc);
    checks++;
    if (d !== 32'hD4 || cyc != 5 || miss_cnt1 !== 32'd1) begin
      errors++; $display("FAIL sb_data: data=%h lat=%0d miss=%0d, expected D4 5 1", d, cyc, miss_cnt1);
    end
    checks++;
    if (seen_addr[0] !== 32'h3000_0000 || seen_addr[1] !== 32'h3000_0004 ||
        seen_addr[2] !== 32'h3000_0008 || seen_addr[3] !== 32'h3000_000C) begin
      errors++; $display("FAIL sb_addr: %h %h %h %h, expected 30000000 30000004 30000008 3000000c",
                         seen_addr[0], seen_addr[1], seen_addr[2], seen_addr[3]);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] d; logic e; int cyc;
    addr = 32'h8000_0300; ifu_valid = 1'b1;
    @(posedge clock); #1;
    mem_ready = 1'b1; mem_data = 32'h99; mem_err = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (mem_valid0 !== 1'b0 || ifu_ready0 !== 1'b0 || hit_cnt0 !== 32'd0 || miss_cnt0 !== 32'd0) begin
      errors++; $display("FAIL reset_mid: mem_valid=%b ready=%b hit=%0d miss=%0d, expected 0 0 0 0", mem_valid0, ifu_ready0, hit_cnt0, miss_cnt0);
    end
    reset = 1'b0; ifu_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clock); #1;
    set_beats(32'h71, 32'h72, 32'h73, 32'h74);
    fetch(32'h8000_0204, -1, -1, 0, d, e, cyc);
    checks++;
    if (d !== 32'h72 || cyc != 5 || miss_cnt0 !== 32'd1) begin
      errors++; $display("FAIL reset_invalid: data=%h lat=%0d miss=%0d, expected 72 5 1", d, cyc, miss_cnt0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    test_reset();
    test_cold_miss();
    test_conflict();
    test_mem_err();
    test_flush();
    test_single_beat();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
